// File: rtl/seletor_jogador_if.sv
// rtl/seletor_jogador_if.sv - player-choice front end bus: raw buttons and window in, choice code and strobe out
interface seletor_jogador_if;
  logic       habilita;
  logic [4:0] botoes;
  logic       botao_pular;
  logic       botao_confirma;
  logic [2:0] jogador_escolhido;
  logic       escolha_valida;
  logic [2:0] db_estado;

  modport master (
    output habilita, botoes, botao_pular, botao_confirma,
    input  jogador_escolhido, escolha_valida, db_estado
  );

  modport slave (
    input  habilita, botoes, botao_pular, botao_confirma,
    output jogador_escolhido, escolha_valida, db_estado
  );
endinterface

// File: rtl/seletor_jogador.sv
// rtl/seletor_jogador.sv - debounced player/skip/confirm buttons feeding a candidate-selection FSM
module seletor_jogador #(
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic           clock,
  input  logic           reset,
  seletor_jogador_if.slave bus
);

  localparam int NB = 7;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    AGUARDA     = 3'd1,
    SELECIONADO = 3'd2,
    CONFIRMA    = 3'd3,
    ESPERA      = 3'd4
  } estado_t;

  // bit order: 0-4 players, 5 skip, 6 confirm
  logic [NB-1:0] raw, sync1, sync2, nivel, nivel_ant, pulso;
  logic [CW-1:0] cnt [NB];

  assign raw = {bus.botao_confirma, bus.botao_pular, bus.botoes};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nivel <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == nivel[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          nivel[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nivel_ant <= '0;
      pulso     <= '0;
    end else begin
      nivel_ant <= nivel;
      pulso     <= nivel & ~nivel_ant;
    end
  end

  logic       sel_valida;
  logic [2:0] sel_codigo;
  logic       confirma;

  // scan downward so the lowest player index overrides; skip is the fallback code
  always_comb begin
    sel_valida = |pulso[5:0];
    sel_codigo = 3'd5;
    for (int i = 4; i >= 0; i--) begin
      if (pulso[i]) sel_codigo = 3'(i);
    end
  end

  assign confirma = pulso[6];

  estado_t    estado, estado_prox;
  logic [2:0] candidato, candidato_prox;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      candidato <= 3'd7;
    end else begin
      estado    <= estado_prox;
      candidato <= candidato_prox;
    end
  end

  always_comb begin
    estado_prox    = estado;
    candidato_prox = candidato;
    if (!bus.habilita && estado != OCIOSO) begin
      estado_prox    = OCIOSO;
      candidato_prox = 3'd7;
    end else begin
      case (estado)
        OCIOSO: begin
          candidato_prox = 3'd7;
          if (bus.habilita) estado_prox = AGUARDA;
        end
        AGUARDA: begin
          if (sel_valida) begin
            candidato_prox = sel_codigo;
            estado_prox    = SELECIONADO;
          end
        end
        SELECIONADO: begin
          // confirm wins over a simultaneous selection and keeps the old candidate
          if (confirma)        estado_prox    = CONFIRMA;
          else if (sel_valida) candidato_prox = sel_codigo;
        end
        CONFIRMA: estado_prox = ESPERA;
        ESPERA:   estado_prox = ESPERA;
        default: begin
          estado_prox    = OCIOSO;
          candidato_prox = 3'd7;
        end
      endcase
    end
  end

  always_comb begin
    bus.db_estado      = estado;
    bus.escolha_valida = (estado == CONFIRMA);
    if (estado == OCIOSO || estado == AGUARDA) bus.jogador_escolhido = 3'd7;
    else                                       bus.jogador_escolhido = candidato;
  end

endmodule

// File: tb/tb_seletor_jogador.sv
// tb/tb_seletor_jogador.sv - scoreboard bench for seletor_jogador with DEBOUNCE_CYCLES=4
module tb_seletor_jogador;

  logic clock = 1'b0;
  logic reset;

  seletor_jogador_if sif ();

  seletor_jogador #(.DEBOUNCE_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clock = ~clock;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;
  logic [2:0] sb [$];
  logic [2:0] exp_code;

  // every strobe must match the next queued expected choice
  always @(negedge clock) begin
    if (reset === 1'b0 && sif.escolha_valida === 1'b1) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got strobe with code %0d, required no strobe", sif.jogador_escolhido);
      end else begin
        exp_code = sb.pop_front();
        if (sif.jogador_escolhido !== exp_code) begin
          errors++;
          $display("FAIL strobe_code: got %0d, required %0d", sif.jogador_escolhido, exp_code);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic [6:0] m);
    {sif.botao_confirma, sif.botao_pular, sif.botoes} = m;
  endtask

  task automatic press(input logic [6:0] m, input int hold);
    drive(m);
    tick(hold);
    drive(7'b0);
    tick(8);
  endtask

  task automatic reopen();
    sif.habilita = 1'b0;
    tick(2);
    sif.habilita = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    checks++;
    if (sif.jogador_escolhido !== 3'd7 || sif.escolha_valida !== 1'b0 || sif.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d/%0d/%0d, required 7/0/0",
               sif.jogador_escolhido, sif.escolha_valida, sif.db_estado);
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if (sif.db_estado !== 3'd0 || sif.jogador_escolhido !== 3'd7) begin
      errors++;
      $display("FAIL idle_closed: got state %0d code %0d, required 0 and 7", sif.db_estado, sif.jogador_escolhido);
    end
  endtask

  task automatic test_select_confirm();
    int s0;
    sif.habilita = 1'b1;
    tick(2);
    checks++;
    if (sif.db_estado !== 3'd1) begin
      errors++;
      $display("FAIL enter_aguarda: got %0d, required 1", sif.db_estado);
    end
    drive(7'b0001000);
    tick(7);
    checks++;
    if (sif.jogador_escolhido !== 3'd7) begin
      errors++;
      $display("FAIL latency_early: got %0d, required 7", sif.jogador_escolhido);
    end
    tick(1);
    checks++;
    if (sif.jogador_escolhido !== 3'd3 || sif.db_estado !== 3'd2) begin
      errors++;
      $display("FAIL latency_select: got code %0d state %0d, required 3 and 2", sif.jogador_escolhido, sif.db_estado);
    end
    tick(2);
    drive(7'b0);
    tick(8);
    s0 = strobes;
    sb.push_back(3'd3);
    press(7'b1000000, 10);
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL confirm_strobe_count: got %0d, required 1", strobes - s0);
    end
    checks++;
    if (sif.db_estado !== 3'd4 || sif.jogador_escolhido !== 3'd3) begin
      errors++;
      $display("FAIL espera_hold: got state %0d code %0d, required 4 and 3", sif.db_estado, sif.jogador_escolhido);
    end
  endtask

  task automatic test_confirm_ignored();
    int s0;
    reopen();
    s0 = strobes;
    press(7'b1000000, 10);
    checks++;
    if (strobes - s0 != 0 || sif.jogador_escolhido !== 3'd7 || sif.db_estado !== 3'd1) begin
      errors++;
      $display("FAIL confirm_in_aguarda: got strobes %0d code %0d state %0d, required 0/7/1",
               strobes - s0, sif.jogador_escolhido, sif.db_estado);
    end
  endtask

  task automatic test_pular_priority();
    int s0;
    press(7'b0010000, 10);
    checks++;
    if (sif.jogador_escolhido !== 3'd4) begin
      errors++;
      $display("FAIL select_p4: got %0d, required 4", sif.jogador_escolhido);
    end
    press(7'b0100000, 10);
    checks++;
    if (sif.jogador_escolhido !== 3'd5) begin
      errors++;
      $display("FAIL select_pular: got %0d, required 5", sif.jogador_escolhido);
    end
    s0 = strobes;
    sb.push_back(3'd5);
    press(7'b1000000, 10);
    checks++;
    if (strobes - s0 != 1 || sif.db_estado !== 3'd4) begin
      errors++;
      $display("FAIL confirm_pular: got strobes %0d state %0d, required 1 and 4", strobes - s0, sif.db_estado);
    end
    reopen();
    press(7'b0101010, 10);
    checks++;
    if (sif.jogador_escolhido !== 3'd1 || sif.db_estado !== 3'd2) begin
      errors++;
      $display("FAIL priority_multi: got code %0d state %0d, required 1 and 2", sif.jogador_escolhido, sif.db_estado);
    end
  endtask

  task automatic test_glitch_bounce();
    logic [24:0] seq;
    logic [2:0]  prev;
    int          changes;
    drive(7'b0000100);
    tick(3);
    drive(7'b0);
    tick(10);
    checks++;
    if (sif.jogador_escolhido !== 3'd1) begin
      errors++;
      $display("FAIL glitch_rejected: got %0d, required 1", sif.jogador_escolhido);
    end
    seq     = 25'b1101110_11111111_0000000000;
    prev    = sif.jogador_escolhido;
    changes = 0;
    for (int i = 24; i >= 0; i--) begin
      drive({3'b000, seq[i], 3'b000});
      @(negedge clock);
      if (sif.jogador_escolhido !== prev) begin
        changes++;
        prev = sif.jogador_escolhido;
      end
    end
    checks++;
    if (changes != 1 || sif.jogador_escolhido !== 3'd3) begin
      errors++;
      $display("FAIL bounce_single: got %0d changes final %0d, required 1 change final 3", changes, sif.jogador_escolhido);
    end
  endtask

  task automatic test_habilita_drop();
    int s0;
    s0 = strobes;
    drive(7'b1000000);
    tick(7);
    checks++;
    if (sif.db_estado !== 3'd2) begin
      errors++;
      $display("FAIL pre_drop_state: got %0d, required 2", sif.db_estado);
    end
    sif.habilita = 1'b0;
    tick(1);
    checks++;
    if (sif.db_estado !== 3'd0 || sif.jogador_escolhido !== 3'd7 || sif.escolha_valida !== 1'b0) begin
      errors++;
      $display("FAIL drop_priority: got state %0d code %0d strobe %0d, required 0/7/0",
               sif.db_estado, sif.jogador_escolhido, sif.escolha_valida);
    end
    tick(3);
    drive(7'b0);
    tick(8);
    checks++;
    if (strobes - s0 != 0) begin
      errors++;
      $display("FAIL drop_no_strobe: got %0d strobes, required 0", strobes - s0);
    end
  endtask

  task automatic test_async_reset();
    int s0;
    sif.habilita = 1'b1;
    tick(2);
    press(7'b0000100, 10);
    s0 = strobes;
    sb.push_back(3'd2);
    press(7'b1000000, 10);
    checks++;
    if (strobes - s0 != 1 || sif.db_estado !== 3'd4 || sif.jogador_escolhido !== 3'd2) begin
      errors++;
      $display("FAIL espera_cand2: got strobes %0d state %0d code %0d, required 1/4/2",
               strobes - s0, sif.db_estado, sif.jogador_escolhido);
    end
    drive(7'b0000001);
    tick(3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sif.jogador_escolhido !== 3'd7 || sif.escolha_valida !== 1'b0 || sif.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got %0d/%0d/%0d, required 7/0/0",
               sif.jogador_escolhido, sif.escolha_valida, sif.db_estado);
    end
    tick(2);
    reset = 1'b0;
    tick(7);
    checks++;
    if (sif.jogador_escolhido !== 3'd7 || sif.db_estado !== 3'd1) begin
      errors++;
      $display("FAIL held_early: got code %0d state %0d, required 7 and 1", sif.jogador_escolhido, sif.db_estado);
    end
    tick(1);
    checks++;
    if (sif.jogador_escolhido !== 3'd0) begin
      errors++;
      $display("FAIL held_reselect: got %0d, required 0", sif.jogador_escolhido);
    end
    drive(7'b0);
    tick(8);
  endtask

  initial begin
    reset        = 1'b1;
    sif.habilita = 1'b0;
    drive(7'b0);
    tick(2);
    test_reset();
    test_select_confirm();
    test_confirm_ignored();
    test_pular_priority();
    test_glitch_bounce();
    test_habilita_drop();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seletor_jogador.md
# seletor_jogador

Player-choice input front end for the game datapath. Debounces the five player buttons, the skip button and the confirm button, and tracks the current candidate. On confirm it presents the chosen code on `jogador_escolhido` with a one-cycle `escolha_valida` strobe, which the control unit turns into `processar_acao` or `voto`. It drives the exact choice encoding the datapath consumes: 0–4 = player, 5 = skip ("pular"), 7 = no choice.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500: consecutive stable cycles needed before a debounced level changes; minimum 1.

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state to reset values.
- `habilita`  in  1  selection window open (level, from control unit).
- `botoes`  in  5  raw player buttons, active-high, bit i = player i, asynchronous to `clock`.
- `botao_pular`  in  1  raw skip button, active-high.
- `botao_confirma`  in  1  raw confirm button, active-high.
- `jogador_escolhido`  out  3  current choice code: 0–4, 5 or 7.
- `escolha_valida`  out  1  one-cycle strobe; choice is final.
- `db_estado`  out  3  FSM state code, for debug.

## Operation
- Input conditioning is identical for all 7 buttons:
  - 2-FF synchronizer.
  - Debouncer: the debounced level flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing cycle clears the counter.
  - Rising-edge detector on the debounced level, producing a 1-cycle pulse.
- Candidate register: 3 bits, reset value 7.
- FSM states:
  - OCIOSO=0
  - AGUARDA=1
  - SELECIONADO=2
  - CONFIRMA=3
  - ESPERA=4
- OCIOSO:
  - candidate = 7.
  - `habilita`=1 → AGUARDA.
- AGUARDA:
  - Any selection pulse loads the candidate → SELECIONADO.
  - Confirm pulse is ignored.
- SELECIONADO:
  - A new selection pulse overwrites the candidate; state is unchanged.
  - Confirm pulse → CONFIRMA.
- CONFIRMA:
  - Lasts exactly one cycle; `escolha_valida`=1.
  - → ESPERA unconditionally.
- ESPERA:
  - Candidate frozen; all button pulses ignored.
  - Leaves only when `habilita` drops.
- `habilita`=0 in any state other than OCIOSO → OCIOSO next edge, candidate cleared to 7. This has priority over every other transition, including a confirm pulse in the same cycle.
- Selection priority when several pulses occur in one cycle: lowest player index wins. `botao_pular` (code 5) only wins if no player pulse is present.
- Selection and confirm pulse in the same cycle in SELECIONADO: confirm uses the previously registered candidate, and the new selection is discarded.
- Outputs:
  - `jogador_escolhido` = 7 in OCIOSO/AGUARDA, otherwise the candidate.
  - `escolha_valida` = (state==CONFIRMA).
- The block does not check for dead players or self-targeting; the datapath enforces game rules.
- Held buttons produce one pulse only, so a button held across window reopening does not reselect.

## Timing
- Reset values:
  - `jogador_escolhido`=7, `escolha_valida`=0, `db_estado`=0.
  - Synchronizers, debounced levels and edge history all cleared to 0; counters cleared to 0.
- A raw press stable before edge k raises the edge pulse after edge k+2+`DEBOUNCE_CYCLES`. The candidate/state updates on the following edge: total latency `DEBOUNCE_CYCLES`+3 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- Confirm press with state SELECIONADO: `escolha_valida` high for the cycle after the confirm pulse is sampled. `jogador_escolhido` is valid in that same cycle and stays stable until `habilita` falls.
- `habilita` falling: outputs return to 7/0 one cycle later.
- Asynchronous reset mid-window: outputs return to reset values immediately. A button still held after reset release yields one fresh pulse once debounced.

## Test plan
All with `DEBOUNCE_CYCLES`=4.
- Reset, `habilita`=1, press `botoes`[3] for 10 cycles → `jogador_escolhido`=3 at cycle 7 after press; press confirm → `escolha_valida`=1 for exactly one cycle with `jogador_escolhido`=3; `db_estado` ends at 4.
- In AGUARDA press confirm only → no strobe, `jogador_escolhido` stays 7, `db_estado`=1.
- Press `botoes`[4] then `botao_pular` → candidate 4 then 5; confirm → strobe with 5. Simultaneous `botoes`=5'b01010 plus pular → candidate 1.
- 3-cycle pulse on `botoes`[2] → no candidate change. Bouncing input that finally holds 4+ cycles → exactly one update.
- Confirm and `habilita`=0 in the same cycle in SELECIONADO → no strobe, next state OCIOSO, output 7.
- Assert `reset` in ESPERA with candidate 2 → outputs 7/0/0 without a clock edge. With `botoes`[0] held through reset release → candidate 0 after 7 cycles once `habilita`=1.
